// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Arithmetic/logic ops finish in one cycle. Shifts and rotates move one bit
// per cycle. MUL is an unsigned iterative shift-add, one multiplier bit per
// cycle. The result and status flags are registered when the op enters DONE.
// They stay there until the consumer takes them, and they are still held in
// IDLE afterwards.
//
// Ports
//   Clk, Reset_n        clock; synchronous active-low reset
//   InputA, InputB [W]  operands, latched on acceptance
//   OP [Ops]            opcode (ADD..CLC, see localparams)
//   In_valid/In_ready   request handshake (In_ready = IDLE)
//   Out_valid/Out_ready result handshake (Out_valid = DONE)
//   Out, OutHi [W]      result low word / MUL high word (0 otherwise)
//   Zero, Parity, Odd,
//   Carry               registered status flags
//   Busy                state != IDLE
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [Ops-1:0] OP,
    input  logic           In_valid,
    output logic           In_ready,
    output logic           Out_valid,
    input  logic           Out_ready,
    output logic [W-1:0]   Out,
    output logic [W-1:0]   OutHi,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           Carry,
    output logic           Busy
);

    localparam int SW = $clog2(W);
    // The counter must be able to hold W itself (full-width shift / MUL).
    localparam int CW = SW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_ADC = Ops'(1);
    localparam logic [Ops-1:0] OP_SUB = Ops'(2);
    localparam logic [Ops-1:0] OP_SBB = Ops'(3);
    localparam logic [Ops-1:0] OP_XOR = Ops'(4);
    localparam logic [Ops-1:0] OP_ORR = Ops'(5);
    localparam logic [Ops-1:0] OP_AND = Ops'(6);
    localparam logic [Ops-1:0] OP_RXR = Ops'(7);
    localparam logic [Ops-1:0] OP_LSH = Ops'(8);
    localparam logic [Ops-1:0] OP_RSH = Ops'(9);
    localparam logic [Ops-1:0] OP_ASR = Ops'(10);
    localparam logic [Ops-1:0] OP_ROL = Ops'(11);
    localparam logic [Ops-1:0] OP_ROR = Ops'(12);
    localparam logic [Ops-1:0] OP_MUL = Ops'(13);
    localparam logic [Ops-1:0] OP_CLC = Ops'(15);

    localparam logic [CW-1:0] W_CNT   = CW'(W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [W-1:0]  W_VAL   = W'(W);

    // ---------------- state ----------------
    logic [1:0]     state_q,  state_d;
    logic [W-1:0]   a_q,      a_d;       // latched A (MUL multiplicand)
    logic [Ops-1:0] op_q,     op_d;
    logic [W-1:0]   work_q,   work_d;    // shift operand / MUL low product word
    logic [W-1:0]   hi_q,     hi_d;      // MUL high product word
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [W-1:0]   out_q,    out_d;
    logic [W-1:0]   outhi_q,  outhi_d;
    logic           zero_q,   zero_d;
    logic           parity_q, parity_d;
    logic           odd_q,    odd_d;
    logic           carry_q,  carry_d;

    // ---------------- incoming-op decode ----------------
    logic          in_is_shift;
    logic [CW-1:0] n_in;

    always_comb begin
        in_is_shift = 1'b0;
        n_in        = '0;
        case (OP)
            OP_LSH, OP_RSH, OP_ASR: begin
                in_is_shift = 1'b1;
                // Linear shifts saturate at W: everything is shifted out.
                n_in = (InputB >= W_VAL) ? W_CNT : InputB[CW-1:0];
            end
            OP_ROL, OP_ROR: begin
                in_is_shift = 1'b1;
                n_in = {1'b0, InputB[SW-1:0]};
            end
            default: ;
        endcase
    end

    // Single-cycle arithmetic. The extra top bit is the carry or the borrow.
    // A W+1-bit subtract wraps there exactly when the true result is negative.
    logic [W:0] cin_ext, add_s, adc_s, sub_s, sbb_s;

    always_comb begin
        cin_ext = {{W{1'b0}}, carry_q};
        add_s   = {1'b0, InputA} + {1'b0, InputB};
        adc_s   = {1'b0, InputA} + {1'b0, InputB} + cin_ext;
        sub_s   = {1'b0, InputA} - {1'b0, InputB};
        sbb_s   = {1'b0, InputA} - {1'b0, InputB} - cin_ext;
    end

    // ---------------- one shift step ----------------
    logic [W-1:0] sh_val;
    logic         sh_bit;    // bit leaving (or wrapping around) this step

    always_comb begin
        sh_val = work_q;
        sh_bit = 1'b0;
        case (op_q)
            OP_LSH: begin sh_bit = work_q[W-1]; sh_val = {work_q[W-2:0], 1'b0};        end
            OP_RSH: begin sh_bit = work_q[0];   sh_val = {1'b0, work_q[W-1:1]};        end
            OP_ASR: begin sh_bit = work_q[0];   sh_val = {work_q[W-1], work_q[W-1:1]}; end
            OP_ROL: begin sh_bit = work_q[W-1]; sh_val = {work_q[W-2:0], work_q[W-1]}; end
            OP_ROR: begin sh_bit = work_q[0];   sh_val = {work_q[0], work_q[W-1:1]};   end
            default: ;
        endcase
    end

    // ---------------- one shift-add multiply step ----------------
    // The multiplier sits in work_q and is consumed from bit 0. The partial
    // product shifts right into work_q as the multiplier bits are used up.
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi, mul_lo;

    always_comb begin
        mul_sum = work_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
        mul_hi  = mul_sum[W:1];
        mul_lo  = {mul_sum[0], work_q[W-1:1]};
    end

    // ---------------- next state ----------------
    logic         ld;        // result enters DONE this cycle
    logic [W-1:0] res_lo, res_hi;
    logic         res_c;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        op_d     = op_q;
        work_d   = work_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        outhi_d  = outhi_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        odd_d    = odd_q;
        carry_d  = carry_q;
        ld       = 1'b0;
        res_lo   = '0;
        res_hi   = '0;
        res_c    = carry_q;

        case (state_q)
            S_IDLE: begin
                if (In_valid) begin
                    a_d  = InputA;
                    op_d = OP;
                    if (in_is_shift && (n_in != '0)) begin
                        work_d  = InputA;
                        cnt_d   = n_in;
                        state_d = S_SHIFT;
                    end else if (OP == OP_MUL) begin
                        work_d  = InputB;
                        hi_d    = '0;
                        cnt_d   = W_CNT;
                        state_d = S_MUL;
                    end else begin
                        ld = 1'b1;
                        case (OP)
                            OP_ADD: begin res_lo = add_s[W-1:0]; res_c = add_s[W]; end
                            OP_ADC: begin res_lo = adc_s[W-1:0]; res_c = adc_s[W]; end
                            OP_SUB: begin res_lo = sub_s[W-1:0]; res_c = sub_s[W]; end
                            OP_SBB: begin res_lo = sbb_s[W-1:0]; res_c = sbb_s[W]; end
                            OP_XOR: res_lo = InputA ^ InputB;
                            OP_ORR: res_lo = InputA | InputB;
                            OP_AND: res_lo = InputA & InputB;
                            OP_RXR: res_lo = {{(W-1){1'b0}}, ^InputA};
                            // Zero-count shift/rotate: operand passes through.
                            OP_LSH, OP_RSH, OP_ASR,
                            OP_ROL, OP_ROR: res_lo = InputA;
                            OP_CLC: res_c = 1'b0;
                            default: ;  // NOP and unused codes: Out = 0
                        endcase
                    end
                end
            end

            S_SHIFT: begin
                work_d = sh_val;
                cnt_d  = cnt_q - CNT_ONE;
                // The last step goes straight into DONE, so a count of n is
                // ready n+1 cycles after acceptance.
                if (cnt_q == CNT_ONE) begin
                    ld     = 1'b1;
                    res_lo = sh_val;
                    res_c  = sh_bit;
                end
            end

            S_MUL: begin
                work_d = mul_lo;
                hi_d   = mul_hi;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    ld     = 1'b1;
                    res_lo = mul_lo;
                    res_hi = mul_hi;
                    res_c  = |mul_hi;
                end
            end

            S_DONE: begin
                if (Out_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (ld) begin
            out_d    = res_lo;
            outhi_d  = res_hi;
            zero_d   = ~|{res_hi, res_lo};
            parity_d = ^res_lo;
            odd_d    = res_lo[0];
            carry_d  = res_c;
            state_d  = S_DONE;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            op_q     <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            outhi_q  <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            odd_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            op_q     <= op_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            outhi_q  <= outhi_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            odd_q    <= odd_d;
            carry_q  <= carry_d;
        end
    end

    assign In_ready  = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign Out_valid = (state_q == S_DONE);
    assign Out       = out_q;
    assign OutHi     = outhi_q;
    assign Zero      = zero_q;
    assign Parity    = parity_q;
    assign Odd       = odd_q;
    assign Carry     = carry_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (W=8).
// A directed vector table, hand-written handshake and reset sequences, and
// random ops checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_mc;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] InputA = '0, InputB = '0;
    logic [3:0] OP = '0;
    logic       In_valid = 1'b0, Out_ready = 1'b0;
    logic       In_ready, Out_valid, Zero, Parity, Odd, Carry, Busy;
    logic [7:0] Out, OutHi;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mcarry = 1'b0;

    alu_mc #(.W(W), .Ops(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InputA(InputA), .InputB(InputB), .OP(OP),
        .In_valid(In_valid), .In_ready(In_ready), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Out(Out), .OutHi(OutHi), .Zero(Zero),
        .Parity(Parity), .Odd(Odd), .Carry(Carry), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written from the opcode definitions with plain integers.
    function automatic void model(input int a, input int b, input int op, input bit cin,
                                  output int lo, output int hi, output bit c, output int lat);
        int s, n, sa;
        lo = 0; hi = 0; c = cin; lat = 1;
        case (op)
            0:  begin s = a + b;       lo = s & MASK; c = (s > MASK); end
            1:  begin s = a + b + cin; lo = s & MASK; c = (s > MASK); end
            2:  begin s = a - b;       lo = s & MASK; c = (s < 0);    end
            3:  begin s = a - b - cin; lo = s & MASK; c = (s < 0);    end
            4:  lo = a ^ b;
            5:  lo = a | b;
            6:  lo = a & b;
            7:  lo = ^a;
            8, 9, 10: begin
                n = (b > W) ? W : b;
                if (n == 0) lo = a;
                else begin
                    lat = n + 1;
                    if (op == 8) begin
                        lo = (a << n) & MASK; c = (a >> (W - n)) & 1;
                    end else if (op == 9) begin
                        lo = a >> n;          c = (a >> (n - 1)) & 1;
                    end else begin
                        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
                        lo = (sa >>> n) & MASK; c = (sa >>> (n - 1)) & 1;
                    end
                end
            end
            11, 12: begin
                n = b % W;
                if (n == 0) lo = a;
                else begin
                    lat = n + 1;
                    if (op == 11) begin
                        lo = ((a << n) | (a >> (W - n))) & MASK; c = lo & 1;
                    end else begin
                        lo = ((a >> n) | (a << (W - n))) & MASK; c = (lo >> (W - 1)) & 1;
                    end
                end
            end
            13: begin
                s = a * b; lo = s & MASK; hi = (s >> W) & MASK; c = (hi != 0); lat = W + 1;
            end
            14: lo = 0;
            default: begin lo = 0; c = 1'b0; end
        endcase
    endfunction

    // Issue one op. Measure its latency and check the result and flags.
    // Hold Out_ready low for 'hold' cycles with In_valid high, then retire.
    task automatic run_op(input string tag, input int a, input int b, input int op, input int hold,
                          input int elo, input int ehi, input bit ec, input int elat);
        int lat;
        logic [7:0] lo8;
        logic [7:0] so, sh;
        logic [3:0] sf;
        lo8 = elo[7:0];
        @(negedge Clk);
        InputA = a[7:0]; InputB = b[7:0]; OP = op[3:0]; In_valid = 1'b1;
        chk({tag, ".in_ready"}, In_ready, 1);
        @(posedge Clk); #1;
        // Operands change after acceptance and must have no effect.
        InputA = 8'($urandom); InputB = 8'($urandom); OP = 4'($urandom);
        In_valid = (hold > 0);
        lat = 1;
        while (!Out_valid && lat < 100) begin
            @(posedge Clk); #1; lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".out"},     Out, elo);
        chk({tag, ".outhi"},   OutHi, ehi);
        chk({tag, ".carry"},   Carry, ec);
        chk({tag, ".zero"},    Zero, (elo == 0 && ehi == 0));
        chk({tag, ".par_odd"}, {Parity, Odd}, {^lo8, lo8[0]});
        so = Out; sh = OutHi; sf = {Zero, Parity, Odd, Carry};
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk({tag, ".hold"}, {Out_valid, In_ready, Busy, Out, OutHi, Zero, Parity, Odd, Carry},
                {3'b101, so, sh, sf});
        end
        Out_ready = 1'b1;
        @(posedge Clk); #1;
        Out_ready = 1'b0; In_valid = 1'b0;
        chk({tag, ".retire"}, {Out_valid, In_ready, Busy}, 3'b010);
        chk({tag, ".retain"}, {Out, OutHi}, {lo8, sh});
    endtask

    typedef struct {
        int a; int b; int op; int hold;
        int lo; int hi; bit c; int lat;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int lo, hi, lat, a, b, op, vcnt;
        bit c;

        tbl[0]  = '{8'hF0, 8'h20, 0,  0, 8'h10, 0,     1'b1, 1};  // ADD carry out
        tbl[1]  = '{8'h01, 8'h01, 1,  0, 8'h03, 0,     1'b0, 1};  // ADC uses carry
        tbl[2]  = '{8'h05, 8'h07, 2,  0, 8'hFE, 0,     1'b1, 1};  // SUB borrow
        tbl[3]  = '{8'h10, 8'h01, 3,  0, 8'h0E, 0,     1'b0, 1};  // SBB uses borrow
        tbl[4]  = '{8'h81, 3,     8,  0, 8'h08, 0,     1'b0, 4};  // LSH by 3
        tbl[5]  = '{8'h80, 9,     10, 0, 8'hFF, 0,     1'b1, 9};  // ASR saturated count
        tbl[6]  = '{8'h01, 9,     12, 0, 8'h80, 0,     1'b1, 2};  // ROR count mod W
        tbl[7]  = '{8'hFF, 8'hFF, 13, 5, 8'h01, 8'hFE, 1'b1, 9};  // MUL, 5-cycle backpressure
        tbl[8]  = '{8'h00, 8'h37, 13, 0, 8'h00, 0,     1'b0, 9};  // MUL zero
        tbl[9]  = '{8'hFF, 8'h01, 0,  0, 8'h00, 0,     1'b1, 1};  // ADD wrap to zero
        tbl[10] = '{8'h12, 8'h34, 14, 0, 8'h00, 0,     1'b1, 1};  // NOP keeps carry
        tbl[11] = '{8'h55, 0,     8,  2, 8'h55, 0,     1'b1, 1};  // LSH by 0 keeps carry
        tbl[12] = '{8'h12, 8'h34, 15, 0, 8'h00, 0,     1'b0, 1};  // CLC
        tbl[13] = '{8'h07, 8'hAA, 7,  0, 8'h01, 0,     1'b0, 1};  // RXR
        tbl[14] = '{8'h80, 1,     11, 0, 8'h01, 0,     1'b1, 2};  // ROL wraps MSB
        tbl[15] = '{8'h81, 8'hC8, 9,  0, 8'h00, 0,     1'b1, 9};  // RSH by 200 -> 8

        // Reset state
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset.outputs", {Out, OutHi, Zero, Parity, Odd, Carry},
            {8'h00, 8'h00, 4'b1000});
        chk("reset.handshake", {Out_valid, In_ready, Busy}, 3'b010);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed table
        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].hold,
                   tbl[i].lo, tbl[i].hi, tbl[i].c, tbl[i].lat);
        mcarry = tbl[15].c;

        // Reset during cycle 4 of a MUL discards it
        run_op("pre_rst", 8'hF0, 8'h20, 0, 0, 8'h10, 0, 1'b1, 1);
        @(negedge Clk);
        InputA = 8'hFF; InputB = 8'hFF; OP = 4'd13; In_valid = 1'b1;
        @(posedge Clk); #1;
        In_valid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        chk("mulrst.state", {Out_valid, In_ready, Busy}, 3'b010);
        chk("mulrst.out", {Out, OutHi, Zero, Carry}, {8'h00, 8'h00, 2'b10});
        Out_ready = 1'b1;
        vcnt = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (Out_valid) vcnt++;
        end
        Out_ready = 1'b0;
        chk("mulrst.no_stale", vcnt, 0);
        mcarry = 1'b0;

        // Random ops against the reference model
        for (int i = 0; i < 300; i++) begin
            a  = $urandom_range(0, 255);
            op = $urandom_range(0, 15);
            if (op >= 8 && op <= 12 && $urandom_range(0, 1) == 1)
                b = $urandom_range(0, 12);
            else
                b = $urandom_range(0, 255);
            model(a, b, op, mcarry, lo, hi, c, lat);
            run_op($sformatf("rnd%0d_op%0d", i, op), a, b, op, $urandom_range(0, 2),
                   lo, hi, c, lat);
            mcarry = c;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter W, default 8, data width; SHALL be a power of two, 4..32.
REQ-002 Parameter Ops, default 4, opcode width; SW = clog2(W) derived locally.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset_n  input  1  reset, synchronous and active-low.
REQ-005 InputA, InputB  input  W  operands, sampled only on acceptance.
REQ-006 OP  input  Ops  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 XOR, 5 ORR, 6 AND, 7 RXR, 8 LSH, 9 RSH, 10 ASR, 11 ROL, 12 ROR, 13 MUL, 14 NOP, 15 CLC.
REQ-007 In_valid  input  1 / In_ready  output  1  request handshake; In_ready SHALL equal (state==IDLE).
REQ-008 Out_valid  output  1 / Out_ready  input  1  result handshake.
REQ-009 Out  output  W  result low word; OutHi  output  W  MUL high word, else 0.
REQ-010 Zero, Parity, Odd, Carry  output  1 each  registered status flags; Busy  output  1  = (state!=IDLE).

Function
REQ-011 States SHALL be IDLE, SHIFT, MUL, DONE; acceptance = In_valid && In_ready.
REQ-012 On acceptance, A, B and OP SHALL be latched; later input changes SHALL have no effect.
REQ-013 Single-cycle ops (0-7, 14, 15, and shifts with n=0) SHALL go IDLE->DONE, Out_valid high 1 cycle after acceptance.
REQ-014 ADD: A+B; ADC: A+B+Carry; Carry = carry-out of bit W-1.
REQ-015 SUB: A-B; SBB: A-B-Carry; Carry = borrow (1 when the true result is negative).
REQ-016 XOR/ORR/AND bitwise; RXR: Out = {0..0, ^A}; Carry unchanged.
REQ-017 NOP: Out=0, Carry unchanged; CLC: Out=0, Carry=0.
REQ-018 Shift count n: LSH/RSH/ASR n = min(B, W); ROL/ROR n = B mod W.
REQ-019 Shift with n>0 SHALL go IDLE->SHIFT, shift one bit per cycle for n cycles, then ->DONE; Out_valid high n+1 cycles after acceptance.
REQ-020 LSH/RSH fill 0; ASR fills with A[W-1]; Carry = last bit shifted out (rotates: last bit wrapped); n=0 leaves Carry unchanged.
REQ-021 MUL: unsigned {OutHi,Out} = A*B by iterative shift-add, one bit per cycle in MUL for W cycles; Out_valid high W+1 cycles after acceptance; Carry = |OutHi.
REQ-022 Zero = ~|{OutHi,Out}; Parity = ^Out; Odd = Out[0]; all registered with the result.
REQ-023 In DONE, Out_valid=1 and Out, OutHi, flags SHALL hold stable until Out_valid && Out_ready, then ->IDLE.
REQ-024 In_ready SHALL be 0 in SHIFT, MUL, DONE; In_valid there SHALL be ignored (max one op per 2 cycles).
REQ-025 In IDLE Out_valid=0; Out, OutHi, flags SHALL retain last result.
REQ-026 Carry SHALL change only when a result enters DONE, per REQ-014..021.

Reset
REQ-027 Reset_n low at a rising edge SHALL force IDLE, Out=0, OutHi=0, Zero=1, Parity=0, Odd=0, Carry=0, Out_valid=0, shift/MUL counters 0.
REQ-028 Reset SHALL take priority over acceptance and over any in-flight op, which SHALL be discarded without producing Out_valid.

Verification
REQ-029 W=8: ADD 0xF0+0x20 -> Out 0x10, Carry 1, latency 1; then ADC 0x01+0x01 -> Out 0x03, Carry 0.
REQ-030 SUB 0x05-0x07 -> Out 0xFE, Carry 1, Parity 1, Odd 0; then SBB 0x10-0x01 -> Out 0x0E, Carry 0.
REQ-031 LSH 0x81 by 3 -> Out 0x08, Carry 0, Out_valid 4 cycles after acceptance; ASR 0x80 by 9 -> Out 0xFF, Carry 1, latency 9; ROR 0x01 by 9 -> Out 0x80, Carry 1, latency 2.
REQ-032 MUL 0xFF*0xFF -> OutHi 0xFE, Out 0x01, Carry 1, Zero 0, latency 9; MUL 0x00*0x37 -> Zero 1.
REQ-033 Out_ready low 5 cycles in DONE with In_valid high -> Out/flags stable, In_ready 0, no new op accepted; result retires on the first Out_ready cycle.
REQ-034 Reset_n low during cycle 4 of a MUL -> next cycle IDLE, Out_valid 0, Out 0, Carry 0, In_ready 1; no stale result emitted.
